block_job_controller: RTL and testbench
=======================================

BLOCK_JOB_CONTROLLER -- requirements
Module: block_job_controller

Interface
REQ-001 Parameter: TIMEOUT_CYCLES, 4096, watchdog limit in clk cycles (used only with JOB_TIMEOUT_EN).
REQ-002 clk  input  1  sole clock; all logic on rising edge.
REQ-003 rst  input  1  synchronous reset, active-high.
REQ-004 wr_en  input  1  host write strobe into source buffer.
REQ-005 wr_addr  input  6  host source-buffer word address.
REQ-006 wr_data  input  32  host source-buffer write data.
REQ-007 rd_addr  input  6  host result-buffer word address.
REQ-008 rd_data  output  32  result-buffer word at rd_addr, combinational.
REQ-009 go  input  1  job request, single-cycle pulse.
REQ-010 clr_done  input  1  clears done and error.
REQ-011 busy  output  1  job in progress.
REQ-012 done  output  1  sticky job-complete flag.
REQ-013 error  output  1  sticky watchdog-abort flag.
REQ-014 start  output  1  level start to worker.
REQ-015 data_in_addr  input  8  worker load address.
REQ-016 data_in  output  32  source word for worker, combinational.
REQ-017 data_out_addr  output  8  result read address to worker, registered.
REQ-018 data_out  input  32  worker result word at data_out_addr, combinational.
REQ-019 state_out  input  4  worker state: 0 IDLE, 1 LOAD_DATA, 2 PROCESS_DATA, 3 SAVE_DATA, 4 DONE.

Function
REQ-020 Source and result buffers SHALL each be 64 x 32 bit.
REQ-021 data_in SHALL equal src[data_in_addr[5:0]] when data_in_addr < 64; otherwise 0.
REQ-022 wr_en SHALL write src[wr_addr] only while busy=0; writes while busy=1 are dropped.
REQ-023 FSM states SHALL be C_IDLE, C_START, C_WAIT, C_READ, C_FINISH, C_RELEASE, C_ERR.
REQ-024 C_IDLE: go=1 -> C_START next cycle; busy=1, done=0, and error=0 from that cycle.
REQ-025 C_START: start=1; state_out=1 -> C_WAIT.
REQ-026 C_WAIT: start=1; state_out=3 -> C_READ with data_out_addr=0.
REQ-027 C_READ: each cycle SHALL write result[data_out_addr[5:0]] <= data_out and increment data_out_addr; after the capture at address 63, data_out_addr=64 -> C_FINISH.
REQ-028 C_FINISH: data_out_addr held at 64, start=1; state_out=4 -> C_RELEASE.
REQ-029 C_RELEASE: start=0; state_out=0 -> C_IDLE with busy=0, done=1, data_out_addr=0.
REQ-030 go while busy=1 SHALL be ignored.
REQ-031 go and clr_done in the same C_IDLE cycle: the job starts and done/error clear.
REQ-032 clr_done while busy=1 SHALL be ignored.
REQ-033 Result buffer SHALL be written only in C_READ; rd_data readable at any time.
REQ-034 Job latency from go to done SHALL be 1 + worker-dependent cycles + 64 read cycles + handshake cycles; the read sweep SHALL take exactly 64 cycles.

Reset
REQ-035 rst=1 SHALL force C_IDLE, start=0, busy=0, done=0, error=0, data_out_addr=0 on the next edge, including mid-job.
REQ-036 Buffer contents SHALL NOT be reset; rd_data after power-up is undefined until the first job.

Configuration
REQ-037 With JOB_TIMEOUT_EN defined, a counter SHALL clear on go and increment each cycle in C_START through C_RELEASE.
REQ-038 With JOB_TIMEOUT_EN defined, when the counter reaches TIMEOUT_CYCLES the FSM SHALL enter C_ERR: start=0, data_out_addr=0, busy=0, done=1, error=1, then C_IDLE next cycle.
REQ-039 Without JOB_TIMEOUT_EN, error SHALL be tied 0, no counter SHALL exist, and handshake waits SHALL be unbounded.

Verification
REQ-040 Write src[i]=i for i=0..63, pulse go, worker inverts -> done=1, rd_addr=5 gives 0xFFFFFFFA, rd_addr=63 gives 0xFFFFFFC0.
REQ-041 data_in_addr=64 during LOAD_DATA -> data_in=0x00000000.
REQ-042 Second go pulse mid-job, then wr_en to address 5 with data 0xDEADBEEF while busy -> one job only; src[5] unchanged and result[5] = ~original.
REQ-043 With JOB_TIMEOUT_EN and state_out stuck at 0 -> error=1 and done=1 exactly 4096 cycles after C_START entry; start=0.
REQ-044 rst=1 at read index 30 -> start=0, busy=0, done=0, data_out_addr=0 next cycle; a fresh go completes normally.
REQ-045 go and clr_done together with done=1 -> done=0 next cycle, busy=1.

Source files
------------

// File: rtl/block_job_controller.sv
// -----------------------------------------------------------------------------
// block_job_controller
//
// Purpose:
//   Sequences one job on an external worker. The host fills a 64 x 32-bit
//   source buffer, pulses go, and the controller drives a level start to the
//   worker. It then follows the worker's state_out handshake, sweeps the
//   worker's result words into a 64 x 32-bit result buffer (one word per
//   cycle, 64 cycles), and releases the worker. busy/done/error report
//   progress to the host.
//
// Optional feature (compile-time macro JOB_TIMEOUT_EN):
//   When defined, a watchdog counts cycles spent in C_START..C_RELEASE. On
//   reaching TIMEOUT_CYCLES the job is aborted through C_ERR, which raises
//   done and error together. When undefined, error is tied low, no counter
//   exists and the handshake waits are unbounded.
//
// Ports:
//   clk            sole clock, rising edge
//   rst            synchronous reset, active high
//   wr_en/wr_addr/wr_data   host writes into the source buffer (dropped while busy)
//   rd_addr/rd_data         host reads of the result buffer (combinational)
//   go             single-cycle job request (ignored while busy)
//   clr_done       clears done/error while idle
//   busy/done/error         job status (registered)
//   start          level start to the worker (registered)
//   data_in_addr/data_in    worker reads of the source buffer (combinational,
//                           0 for addresses >= 64)
//   data_out_addr  registered result-sweep address to the worker
//   data_out       worker result word at data_out_addr
//   state_out      worker state: 0 IDLE, 1 LOAD_DATA, 2 PROCESS_DATA,
//                  3 SAVE_DATA, 4 DONE
// -----------------------------------------------------------------------------
module block_job_controller #(
    parameter int TIMEOUT_CYCLES = 4096
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        wr_en,
    input  logic [5:0]  wr_addr,
    input  logic [31:0] wr_data,
    input  logic [5:0]  rd_addr,
    output logic [31:0] rd_data,
    input  logic        go,
    input  logic        clr_done,
    output logic        busy,
    output logic        done,
    output logic        error,
    output logic        start,
    input  logic [7:0]  data_in_addr,
    output logic [31:0] data_in,
    output logic [7:0]  data_out_addr,
    input  logic [31:0] data_out,
    input  logic [3:0]  state_out
);

    // Worker state encodings observed on state_out.
    localparam logic [3:0] WK_IDLE = 4'd0;
    localparam logic [3:0] WK_LOAD = 4'd1;
    localparam logic [3:0] WK_SAVE = 4'd3;
    localparam logic [3:0] WK_DONE = 4'd4;

    // Last word index of the sweep and the parked address that follows it.
    localparam logic [7:0] LAST_ADDR  = 8'd63;
    localparam logic [7:0] PARK_ADDR  = 8'd64;

    typedef enum logic [2:0] {
        C_IDLE    = 3'd0,
        C_START   = 3'd1,
        C_WAIT    = 3'd2,
        C_READ    = 3'd3,
        C_FINISH  = 3'd4,
        C_RELEASE = 3'd5,
        C_ERR     = 3'd6
    } ctrl_state_t;

    ctrl_state_t r_state;
    logic        r_start;
    logic        r_busy;
    logic        r_done;
    logic [7:0]  r_dout_addr;

    // Buffers: no reset on purpose so they map onto memory resources.
    logic [31:0] r_src [0:63];
    logic [31:0] r_res [0:63];

    logic [31:0] w_src_word;
    logic        w_wd_expired;
    logic        w_job_go;

    // A job is launched only from idle; go at any other time is ignored.
    assign w_job_go = (r_state == C_IDLE) && go;

    // -------------------------------------------------------------------------
    // Source buffer: host write port, worker combinational read port.
    // The host is locked out for the whole job so the worker sees a stable
    // snapshot of the source data.
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (wr_en && !r_busy) begin
            r_src[wr_addr] <= wr_data;
        end
    end

    assign w_src_word = r_src[data_in_addr[5:0]];
    // Addresses beyond the buffer read as zero rather than aliasing.
    assign data_in    = (data_in_addr[7:6] == 2'b00) ? w_src_word : 32'd0;

    // -------------------------------------------------------------------------
    // Result buffer: written only during the read sweep, host reads anytime.
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (r_state == C_READ) begin
            r_res[r_dout_addr[5:0]] <= data_out;
        end
    end

    assign rd_data = r_res[rd_addr];

    // -------------------------------------------------------------------------
    // Optional watchdog
    // -------------------------------------------------------------------------
`ifdef JOB_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [CNT_W-1:0] r_wd_cnt;
    logic             r_error;
    logic             w_wd_active;

    assign w_wd_active = (r_state == C_START)  || (r_state == C_WAIT)   ||
                         (r_state == C_READ)   || (r_state == C_FINISH) ||
                         (r_state == C_RELEASE);

    // The counter value seen at an edge equals the number of edges already
    // spent in the active states, so comparing against TIMEOUT_CYCLES-1
    // lands the abort exactly TIMEOUT_CYCLES edges after C_START entry.
    assign w_wd_expired = w_wd_active &&
                          (r_wd_cnt == CNT_W'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wd_cnt <= '0;
        end else if (w_job_go) begin
            r_wd_cnt <= '0;
        end else if (w_wd_active && !w_wd_expired) begin
            r_wd_cnt <= r_wd_cnt + 1'b1;
        end
    end

    // Sticky abort flag; cleared by a new job or by clr_done while idle.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_error <= 1'b0;
        end else if (w_wd_expired) begin
            r_error <= 1'b1;
        end else if ((r_state == C_IDLE) && (go || clr_done)) begin
            r_error <= 1'b0;
        end
    end

    assign error = r_error;
`else
    logic w_unused_cfg;

    // Without the watchdog the limit parameter has no effect.
    assign w_unused_cfg = (TIMEOUT_CYCLES > 0);
    assign w_wd_expired = 1'b0;
    assign error        = 1'b0;
`endif

    // -------------------------------------------------------------------------
    // Control FSM with registered outputs
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= C_IDLE;
            r_start     <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_dout_addr <= 8'd0;
        end else if (w_wd_expired) begin
            // Watchdog abort overrides whatever the handshake was doing.
            r_state     <= C_ERR;
            r_start     <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b1;
            r_dout_addr <= 8'd0;
        end else begin
            case (r_state)
                C_IDLE: begin
                    if (go) begin
                        // A simultaneous clr_done is covered: done clears here.
                        r_state     <= C_START;
                        r_start     <= 1'b1;
                        r_busy      <= 1'b1;
                        r_done      <= 1'b0;
                        r_dout_addr <= 8'd0;
                    end else if (clr_done) begin
                        r_done <= 1'b0;
                    end
                end

                C_START: begin
                    if (state_out == WK_LOAD) begin
                        r_state <= C_WAIT;
                    end
                end

                C_WAIT: begin
                    if (state_out == WK_SAVE) begin
                        r_state     <= C_READ;
                        r_dout_addr <= 8'd0;
                    end
                end

                C_READ: begin
                    // One word captured per cycle; the address parks at 64
                    // once word 63 has been taken.
                    r_dout_addr <= r_dout_addr + 8'd1;
                    if (r_dout_addr == LAST_ADDR) begin
                        r_state <= C_FINISH;
                    end
                end

                C_FINISH: begin
                    r_dout_addr <= PARK_ADDR;
                    if (state_out == WK_DONE) begin
                        r_state <= C_RELEASE;
                        r_start <= 1'b0;
                    end
                end

                C_RELEASE: begin
                    if (state_out == WK_IDLE) begin
                        r_state     <= C_IDLE;
                        r_busy      <= 1'b0;
                        r_done      <= 1'b1;
                        r_dout_addr <= 8'd0;
                    end
                end

                C_ERR: begin
                    r_state <= C_IDLE;
                end

                default: begin
                    r_state     <= C_IDLE;
                    r_start     <= 1'b0;
                    r_busy      <= 1'b0;
                    r_dout_addr <= 8'd0;
                end
            endcase
        end
    end

    assign start         = r_start;
    assign busy          = r_busy;
    assign done          = r_done;
    assign data_out_addr = r_dout_addr;

endmodule

// File: tb/tb_block_job_controller.sv
// -----------------------------------------------------------------------------
// tb_block_job_controller
//
// Scoreboard bench for block_job_controller. A behavioural worker answers the
// start/state_out handshake, loads the source words, applies a selectable
// operation and serves the results. Expected values come from a shadow copy
// of the source buffer and the same operation applied at launch time; they
// are queued when a probe is issued and popped by a negedge monitor.
// Define JOB_TIMEOUT_EN to also exercise the watchdog abort.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_block_job_controller;

    logic        clk = 1'b0;
    logic        rst;
    logic        wr_en;
    logic [5:0]  wr_addr;
    logic [31:0] wr_data;
    logic [5:0]  rd_addr;
    logic [31:0] rd_data;
    logic        go;
    logic        clr_done;
    logic        busy;
    logic        done;
    logic        error;
    logic        start;
    logic [7:0]  data_in_addr;
    logic [31:0] data_in;
    logic [7:0]  data_out_addr;
    logic [31:0] data_out;
    logic [3:0]  state_out;

    always #5 clk = ~clk;

    block_job_controller dut (
        .clk           (clk),
        .rst           (rst),
        .wr_en         (wr_en),
        .wr_addr       (wr_addr),
        .wr_data       (wr_data),
        .rd_addr       (rd_addr),
        .rd_data       (rd_data),
        .go            (go),
        .clr_done      (clr_done),
        .busy          (busy),
        .done          (done),
        .error         (error),
        .start         (start),
        .data_in_addr  (data_in_addr),
        .data_in       (data_in),
        .data_out_addr (data_out_addr),
        .data_out      (data_out),
        .state_out     (state_out)
    );

    // ---------------- counters and scoreboard ----------------
    int n_checks = 0;
    int n_pass   = 0;

    logic [31:0] q_rd[$];
    logic [31:0] q_din[$];
    logic [31:0] q_flag[$];
    string       q_flag_name[$];

    logic rd_probe   = 1'b0;
    logic din_probe  = 1'b0;
    logic flag_probe = 1'b0;

    function automatic void check(input string name, input logic [31:0] act,
                                  input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h required 0x%08h", name, act, exp);
    endfunction

    function automatic void sb_empty(input string name);
        n_checks++;
        $display("FAIL %s: scoreboard had no expected entry", name);
    endfunction

    // ---------------- reference model ----------------
    logic [31:0] sh_src  [64];
    logic [31:0] exp_res [64];
    int          jobs_issued = 0;

    function automatic logic [31:0] op_fn(input int op, input logic [31:0] key,
                                          input logic [31:0] x);
        case (op)
            0:       return ~x;
            1:       return x ^ key;
            default: return x + key;
        endcase
    endfunction

    // ---------------- monitor ----------------
    always @(negedge clk) begin
        if (rd_probe) begin
            if (q_rd.size() == 0) sb_empty("rd_data");
            else check($sformatf("rd_data[%0d]", rd_addr), rd_data, q_rd.pop_front());
        end
        if (din_probe) begin
            if (q_din.size() == 0) sb_empty("data_in");
            else check($sformatf("data_in[%0d]", data_in_addr), data_in, q_din.pop_front());
        end
        if (flag_probe) begin
            if (q_flag.size() == 0) sb_empty("flags");
            else check($sformatf("flags_%s(start,busy,done,err,addr)", q_flag_name.pop_front()),
                       {20'd0, start, busy, done, error, data_out_addr}, q_flag.pop_front());
        end
    end

    // Sweep length and start-pulse bookkeeping.
    int         cyc = 0;
    int         t_sweep = 0;
    int         n_start_rise = 0;
    logic [7:0] prev_addr = 8'd0;
    logic       prev_start = 1'b0;

    always @(negedge clk) begin
        cyc++;
        if (data_out_addr == 8'd1 && prev_addr == 8'd0) t_sweep = cyc;
        if (data_out_addr == 8'd64 && prev_addr != 8'd64)
            check("sweep_len", cyc - t_sweep, 32'd63);
        if (start === 1'b1 && prev_start !== 1'b1) n_start_rise++;
        prev_addr  = data_out_addr;
        prev_start = start;
    end

    // ---------------- helpers ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // ---------------- behavioural worker ----------------
    int          wk_phase;
    int          wk_idx;
    int          wk_dly;
    int          wk_op = 0;
    logic [31:0] wk_key = 32'd0;
    logic        wk_stuck = 1'b0;
    logic [31:0] wk_buf [64];
    logic [31:0] wk_res [64];

    assign data_out = wk_res[data_out_addr[5:0]];

    initial begin
        state_out    = 4'd0;
        data_in_addr = 8'd0;
        wk_phase     = 0;
        wk_idx       = 0;
        wk_dly       = 0;
        for (int i = 0; i < 64; i++) wk_res[i] = 32'd0;
        forever begin
            tick();
            if (rst) begin
                wk_phase     = 0;
                state_out    = 4'd0;
                data_in_addr = 8'd0;
                din_probe    = 1'b0;
            end else begin
                case (wk_phase)
                    0: if (start === 1'b1 && !wk_stuck) begin
                           wk_dly   = $urandom_range(0, 3);
                           wk_phase = 1;
                       end
                    1: if (wk_dly == 0) begin
                           state_out    = 4'd1;
                           wk_idx       = 0;
                           data_in_addr = 8'd0;
                           q_din.push_back(sh_src[0]);
                           din_probe    = 1'b1;
                           wk_phase     = 2;
                       end else wk_dly--;
                    2: begin
                           if (wk_idx < 64) wk_buf[wk_idx] = data_in;
                           wk_idx++;
                           if (wk_idx <= 64) begin
                               data_in_addr = 8'(wk_idx);
                               // Address 64 is out of range and must read 0.
                               q_din.push_back(wk_idx < 64 ? sh_src[wk_idx] : 32'd0);
                           end else begin
                               din_probe    = 1'b0;
                               data_in_addr = 8'd0;
                               state_out    = 4'd2;
                               for (int i = 0; i < 64; i++)
                                   wk_res[i] = op_fn(wk_op, wk_key, wk_buf[i]);
                               wk_dly   = $urandom_range(0, 5);
                               wk_phase = 3;
                           end
                       end
                    3: if (wk_dly == 0) begin
                           state_out = 4'd3;
                           wk_phase  = 4;
                       end else wk_dly--;
                    4: if (data_out_addr == 8'd64) begin
                           state_out = 4'd4;
                           wk_phase  = 5;
                       end
                    default: if (start === 1'b0) begin
                           state_out = 4'd0;
                           wk_phase  = 0;
                       end
                endcase
            end
        end
    end

    // ---------------- stimulus tasks ----------------
    task automatic host_write(input logic [5:0] a, input logic [31:0] d, input bit upd);
        wr_en = 1'b1; wr_addr = a; wr_data = d;
        tick();
        wr_en = 1'b0;
        if (upd) sh_src[a] = d;
    endtask

    task automatic probe_flags(input string nm, input logic s, input logic b,
                               input logic dn, input logic e, input logic [7:0] a);
        q_flag.push_back({20'd0, s, b, dn, e, a});
        q_flag_name.push_back(nm);
        flag_probe = 1'b1;
        tick();
        flag_probe = 1'b0;
    endtask

    task automatic read_chk(input logic [5:0] a, input logic [31:0] e);
        q_rd.push_back(e);
        rd_addr  = a;
        rd_probe = 1'b1;
        tick();
        rd_probe = 1'b0;
    endtask

    task automatic launch(input int op, input logic [31:0] key, input bit with_clr);
        wk_op  = op;
        wk_key = key;
        for (int i = 0; i < 64; i++) exp_res[i] = op_fn(op, key, sh_src[i]);
        go = 1'b1; clr_done = with_clr;
        tick();
        go = 1'b0; clr_done = 1'b0;
        jobs_issued++;
    endtask

    task automatic wait_done(input string nm);
        int n;
        n = 0;
        while (!(done === 1'b1 && busy === 1'b0) && n < 3000) begin
            tick();
            n++;
        end
        check($sformatf("%s_done", nm), {31'd0, done}, 32'd1);
        $display("job %0d %s: op=%0d finished after %0d cycles", jobs_issued, nm, wk_op, n);
    endtask

    // ---------------- main sequence ----------------
    initial begin
        logic [5:0]  a;
        logic [31:0] orig5;
        logic [31:0] key;
        int          n;

        rst = 1'b1; wr_en = 1'b0; wr_addr = 6'd0; wr_data = 32'd0;
        rd_addr = 6'd0; go = 1'b0; clr_done = 1'b0;
        for (int i = 0; i < 64; i++) begin sh_src[i] = 32'd0; exp_res[i] = 32'd0; end
        repeat (3) tick();
        probe_flags("in_reset", 1'b0, 1'b0, 1'b0, 1'b0, 8'd0);
        rst = 1'b0;
        probe_flags("idle", 1'b0, 1'b0, 1'b0, 1'b0, 8'd0);

        // Directed invert job over an index ramp.
        for (int i = 0; i < 64; i++) host_write(6'(i), 32'(i), 1'b1);
        launch(0, 32'd0, 1'b0);
        wait_done("invert_ramp");
        probe_flags("after_job", 1'b0, 1'b0, 1'b1, 1'b0, 8'd0);
        read_chk(6'd5,  32'hFFFF_FFFA);
        read_chk(6'd63, 32'hFFFF_FFC0);
        for (int k = 0; k < 6; k++) begin
            a = 6'($urandom_range(0, 63));
            read_chk(a, exp_res[a]);
        end

        // go + clr_done together while done=1, then a second go and a
        // source write while busy, both of which must be dropped.
        for (int i = 0; i < 64; i++) host_write(6'(i), $urandom, 1'b1);
        orig5 = sh_src[5];
        key   = $urandom;
        launch(1, key, 1'b1);
        probe_flags("go_with_clr", 1'b1, 1'b1, 1'b0, 1'b0, 8'd0);
        go = 1'b1; tick(); go = 1'b0;
        host_write(6'd5, 32'hDEAD_BEEF, 1'b0);
        wait_done("busy_writes");
        read_chk(6'd5, op_fn(1, key, orig5));
        repeat (20) tick();
        probe_flags("single_job", 1'b0, 1'b0, 1'b1, 1'b0, 8'd0);

        clr_done = 1'b1; tick(); clr_done = 1'b0;
        probe_flags("clr_idle", 1'b0, 1'b0, 1'b0, 1'b0, 8'd0);

        // Reset in the middle of the read sweep.
        launch(2, $urandom, 1'b0);
        n = 0;
        while (data_out_addr !== 8'd30 && n < 2000) begin tick(); n++; end
        check("reach_read_index_30", {24'd0, data_out_addr}, 32'd30);
        rst = 1'b1;
        tick();
        probe_flags("reset_mid_read", 1'b0, 1'b0, 1'b0, 1'b0, 8'd0);
        rst = 1'b0;
        $display("job %0d aborted by reset at read index 30", jobs_issued);

        // Randomized jobs with partial source updates; read back everything.
        for (int j = 0; j < 4; j++) begin
            for (int w = 0; w < 12; w++) host_write(6'($urandom_range(0, 63)), $urandom, 1'b1);
            launch($urandom_range(0, 2), $urandom, 1'($urandom_range(0, 1)));
            wait_done("random");
            probe_flags("random_end", 1'b0, 1'b0, 1'b1, 1'b0, 8'd0);
            for (int i = 0; i < 64; i++) read_chk(6'(i), exp_res[i]);
        end

`ifdef JOB_TIMEOUT_EN
        // Worker never answers: the watchdog aborts 4096 cycles after C_START.
        wk_stuck = 1'b1;
        launch(0, 32'd0, 1'b1);
        repeat (4095) tick();
        probe_flags("before_timeout", 1'b1, 1'b1, 1'b0, 1'b0, 8'd0);
        probe_flags("timeout_err", 1'b0, 1'b0, 1'b1, 1'b1, 8'd0);
        probe_flags("timeout_idle", 1'b0, 1'b0, 1'b1, 1'b1, 8'd0);
        wk_stuck = 1'b0;
        $display("job %0d aborted by watchdog", jobs_issued);
        clr_done = 1'b1; tick(); clr_done = 1'b0;
        probe_flags("clr_error", 1'b0, 1'b0, 1'b0, 1'b0, 8'd0);
`endif

        // Fresh job after all the aborts.
        launch(0, 32'd0, 1'b0);
        wait_done("final");
        for (int i = 0; i < 64; i += 7) read_chk(6'(i), exp_res[i]);

        repeat (3) tick();
        check("start_pulses", n_start_rise, jobs_issued);
        check("scoreboard_drained", q_rd.size() + q_din.size() + q_flag.size(), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not finish, checks %0d", n_checks);
        $fatal(1, "global timeout");
    end

endmodule
